// File: rtl/branch_predictor_bht_if.sv
// Fetch/Decode-facing signal bundle of the branch predictor.
// The master modport is the pipeline side; the slave modport is the predictor side.
interface branch_predictor_bht_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]   pcF;
    logic                  predict_takenF;
    logic [PC_WIDTH-1:0]   predict_targetF;
    logic                  btb_hitF;
    logic                  en;
    logic                  flushD;
    logic                  branchD;
    logic                  takenD;
    logic [PC_WIDTH-1:0]   pcD;
    logic [PC_WIDTH-1:0]   targetD;
    logic                  mispredictD;
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output pcF, en, flushD, branchD, takenD, pcD, targetD,
        input  predict_takenF, predict_targetF, btb_hitF, mispredictD,
               branch_count, mispredict_count
    );

    modport slave (
        input  pcF, en, flushD, branchD, takenD, pcD, targetD,
        output predict_takenF, predict_targetF, btb_hitF, mispredictD,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Saturating-counter branch history table with a tagged BTB, looked up in Fetch, updated from Decode.
// Define GSHARE_EN to XOR a global history register into the counter index.
module branch_predictor_bht #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                   mclk,
    input  logic                   reset,
    branch_predictor_bht_if.slave  bus
);
    localparam int DEPTH    = 1 << INDEX_BITS;
    localparam int TAG_BITS = PC_WIDTH - INDEX_BITS - 2;
    localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]   CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    typedef struct packed {
        logic                  valid;
        logic                  taken;
        logic [PC_WIDTH-1:0]   target;
        logic [INDEX_BITS-1:0] idx;
    } rec_t;

    logic [CTR_BITS-1:0]   r_ctr        [DEPTH];
    logic [DEPTH-1:0]      r_btb_valid;
    logic [TAG_BITS-1:0]   r_btb_tag    [DEPTH];
    logic [PC_WIDTH-1:0]   r_btb_target [DEPTH];
    rec_t                  r_rec;
    logic [STAT_WIDTH-1:0] r_branch_count;
    logic [STAT_WIDTH-1:0] r_mispredict_count;

    logic [INDEX_BITS-1:0] w_pc_idxF;
    logic [INDEX_BITS-1:0] w_idxF;
    logic [TAG_BITS-1:0]   w_tagF;
    logic [INDEX_BITS-1:0] w_pc_idxD;
    logic [TAG_BITS-1:0]   w_tagD;
    logic                  w_btb_hitF;
    logic                  w_predict_takenF;
    logic [PC_WIDTH-1:0]   w_predict_targetF;
    logic                  w_update;
    logic                  w_mispredictD;
    logic [CTR_BITS-1:0]   w_ctr_cur;
    logic [CTR_BITS-1:0]   w_ctr_next;
    logic                  w_unused_bits;

    assign w_pc_idxF = bus.pcF[INDEX_BITS+1:2];
    assign w_tagF    = bus.pcF[PC_WIDTH-1:INDEX_BITS+2];
    assign w_pc_idxD = bus.pcD[INDEX_BITS+1:2];
    assign w_tagD    = bus.pcD[PC_WIDTH-1:INDEX_BITS+2];
    assign w_unused_bits = ^{bus.pcF[1:0], bus.pcD[1:0]};

    assign w_update = bus.en & bus.branchD & ~bus.flushD;

`ifdef GSHARE_EN
    logic [INDEX_BITS-1:0] r_ghr;

    assign w_idxF = w_pc_idxF ^ r_ghr;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset)
            r_ghr <= '0;
        else if (w_update)
            r_ghr <= {r_ghr[INDEX_BITS-2:0], bus.takenD};
    end
`else
    assign w_idxF = w_pc_idxF;
`endif

    // The BTB is always indexed by PC; only the counters see the history hash.
    assign w_btb_hitF        = r_btb_valid[w_pc_idxF] & (r_btb_tag[w_pc_idxF] == w_tagF);
    assign w_predict_takenF  = w_btb_hitF & r_ctr[w_idxF][CTR_BITS-1];
    assign w_predict_targetF = w_btb_hitF ? r_btb_target[w_pc_idxF] : '0;

    assign w_mispredictD = bus.branchD & r_rec.valid &
                           ((r_rec.taken != bus.takenD) |
                            (bus.takenD & (r_rec.target != bus.targetD)));

    assign w_ctr_cur = r_ctr[r_rec.idx];

    // NOTE: assign a default first so every path drives w_ctr_next and no latch is inferred.
    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (bus.takenD && (w_ctr_cur != CTR_MAX))
            w_ctr_next = w_ctr_cur + CTR_BITS'(1);
        else if (!bus.takenD && (w_ctr_cur != '0))
            w_ctr_next = w_ctr_cur - CTR_BITS'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_ctr[i] <= CTR_INIT;
            r_btb_valid <= '0;
        end else if (w_update) begin
            r_ctr[r_rec.idx] <= w_ctr_next;
            if (bus.takenD)
                r_btb_valid[w_pc_idxD] <= 1'b1;
        end
    end

    // NOTE: tag/target storage is not reset; it is only observed through a set valid bit.
    always_ff @(posedge mclk) begin
        if (w_update && bus.takenD) begin
            r_btb_tag[w_pc_idxD]    <= w_tagD;
            r_btb_target[w_pc_idxD] <= bus.targetD;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset)
            r_rec <= '0;
        else if (bus.flushD)
            r_rec.valid <= 1'b0;
        else if (bus.en)
            r_rec <= '{valid: 1'b1, taken: w_predict_takenF,
                       target: w_predict_targetF, idx: w_idxF};
    end

    // Statistics saturate so the display never shows a wrapped, misleadingly small count.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_update) begin
            if (r_branch_count != STAT_MAX)
                r_branch_count <= r_branch_count + STAT_WIDTH'(1);
            if (w_mispredictD && (r_mispredict_count != STAT_MAX))
                r_mispredict_count <= r_mispredict_count + STAT_WIDTH'(1);
        end
    end

    assign bus.btb_hitF         = w_btb_hitF;
    assign bus.predict_takenF   = w_predict_takenF;
    assign bus.predict_targetF  = w_predict_targetF;
    assign bus.mispredictD      = w_mispredictD;
    assign bus.branch_count     = r_branch_count;
    assign bus.mispredict_count = r_mispredict_count;
endmodule
